chacha_inv_permute: RTL and testbench

- Iterative engine that inverts the ChaCha block permutation: takes a 16-word state after ROUNDS rounds and recovers the pre-permutation state.
- No feed-forward add.
- Companion to the forward quarter-round datapath; used for self-check, test vector back-derivation and key-stream analysis.
- One inverse half-round (4 inverse quarter rounds in parallel) per clock, with valid/ready handshakes on input and output.

---
 rtl/chacha_pkg.sv | 35 +++
 rtl/inv_quarter_round.sv | 31 +++
 rtl/chacha_inv_permute.sv | 103 ++++++++++
 tb/tb_chacha_inv_permute.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/chacha_pkg.sv
`default_nettype none
// chacha_pkg: shared state type, quarter-round index tables, sigma words and helpers
// for the inverse ChaCha permutation. Rev 1.0
package chacha_pkg;

  typedef logic [31:0] word_t;
  typedef word_t [15:0] state_t;

  // Row q lists the (a,b,c,d) word positions of quarter round q.
  localparam logic [3:0] COL_IDX [4][4] = '{
    '{4'd0, 4'd4, 4'd8,  4'd12},
    '{4'd1, 4'd5, 4'd9,  4'd13},
    '{4'd2, 4'd6, 4'd10, 4'd14},
    '{4'd3, 4'd7, 4'd11, 4'd15}
  };

  localparam logic [3:0] DIAG_IDX [4][4] = '{
    '{4'd0, 4'd5, 4'd10, 4'd15},
    '{4'd1, 4'd6, 4'd11, 4'd12},
    '{4'd2, 4'd7, 4'd8,  4'd13},
    '{4'd3, 4'd4, 4'd9,  4'd14}
  };

  localparam word_t SIGMA [4] = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic word_t rotr32(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

endpackage
`default_nettype wire

// File: rtl/inv_quarter_round.sv
`default_nettype none
// inv_quarter_round: combinational inverse of one ChaCha quarter round;
// (a,b,c,d) are forward outputs, (a0,b0,c0,d0) the recovered inputs. Rev 1.0
module inv_quarter_round
  import chacha_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  output logic [31:0] a0,
  output logic [31:0] b0,
  output logic [31:0] c0,
  output logic [31:0] d0
);

  logic [31:0] a1, b1, c1, d1;

  // Undo the second half of the forward quarter round first, then the first half.
  assign b1 = rotr32(b, 7) ^ c;
  assign c1 = c - d;
  assign d1 = rotr32(d, 8) ^ a;
  assign a1 = a - b1;

  assign b0 = rotr32(b1, 12) ^ c1;
  assign c0 = c1 - d1;
  assign d0 = rotr32(d1, 16) ^ a1;
  assign a0 = a1 - b0;

endmodule
`default_nettype wire

// File: rtl/chacha_inv_permute.sv
`default_nettype none
// chacha_inv_permute: iterative inverse of the ChaCha block permutation (no feed-forward add).
// CHACHA_INV_UNROLL2_EN: two inverse half-rounds per RUN cycle. Rev 1.0
module chacha_inv_permute
  import chacha_pkg::*;
#(
  parameter int ROUNDS = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_state,
  output logic         busy
);

  localparam int CNT_W = $clog2(ROUNDS + 1);
`ifdef CHACHA_INV_UNROLL2_EN
  localparam int NSTAGE = 2;
`else
  localparam int NSTAGE = 1;
`endif
  localparam logic [CNT_W-1:0] STEP = CNT_W'(NSTAGE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - NSTAGE);

  logic [1:0]       fsm;
  logic [CNT_W-1:0] cnt;
  state_t           st;

  state_t            chain   [NSTAGE+1];
  state_t            col_sc  [NSTAGE];
  state_t            diag_sc [NSTAGE];
  logic [31:0]       qi      [NSTAGE][4][4];
  logic [31:0]       qo      [NSTAGE][4][4];
  logic [NSTAGE-1:0] use_col;

  // Forward rounds end on a diagonal round, so the inverse starts with one.
`ifdef CHACHA_INV_UNROLL2_EN
  assign use_col = 2'b10;
`else
  assign use_col = cnt[0];
`endif

  assign chain[0] = st;

  for (genvar s = 0; s < NSTAGE; s++) begin : g_stage
    for (genvar q = 0; q < 4; q++) begin : g_qr
      for (genvar j = 0; j < 4; j++) begin : g_word
        assign qi[s][q][j] = use_col[s] ? chain[s][COL_IDX[q][j]] : chain[s][DIAG_IDX[q][j]];
        assign col_sc[s][COL_IDX[q][j]]   = qo[s][q][j];
        assign diag_sc[s][DIAG_IDX[q][j]] = qo[s][q][j];
      end
      inv_quarter_round u_iqr (
        .a  (qi[s][q][0]),
        .b  (qi[s][q][1]),
        .c  (qi[s][q][2]),
        .d  (qi[s][q][3]),
        .a0 (qo[s][q][0]),
        .b0 (qo[s][q][1]),
        .c0 (qo[s][q][2]),
        .d0 (qo[s][q][3])
      );
    end
    assign chain[s+1] = use_col[s] ? col_sc[s] : diag_sc[s];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm <= IDLE;
      cnt <= '0;
      st  <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            st  <= in_state;
            cnt <= '0;
            fsm <= RUN;
          end
        end
        RUN: begin
          st  <= chain[NSTAGE];
          cnt <= cnt + STEP;
          if (cnt == LAST) fsm <= DONE;
        end
        DONE: begin
          if (out_ready) fsm <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign in_ready  = (fsm == IDLE);
  assign out_valid = (fsm == DONE);
  assign busy      = (fsm != IDLE);
  assign out_state = st;

endmodule
`default_nettype wire

// File: tb/tb_chacha_inv_permute.sv
`default_nettype none
// tb_chacha_inv_permute: directed and forward-model-derived vectors for the inverse
// ChaCha permutation at ROUNDS = 20, 8 and 12.
`timescale 1ns/1ps
module tb_chacha_inv_permute;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   iv;
  logic [2:0]   ordy;
  logic [511:0] din;
  wire  [2:0]   ir;
  wire  [2:0]   ov;
  wire  [2:0]   bz;
  wire  [511:0] os0, os1, os2;

  logic [31:0] qa, qb, qc, qd;
  wire  [31:0] ra, rb, rc, rd;

  int total = 0;
  int bad   = 0;
  int rnd [3] = '{20, 8, 12};

  always #5 clk = ~clk;

  chacha_inv_permute #(.ROUNDS(20)) u_dut20 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_state(din),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_state(os0), .busy(bz[0]));
  chacha_inv_permute #(.ROUNDS(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_state(din),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_state(os1), .busy(bz[1]));
  chacha_inv_permute #(.ROUNDS(12)) u_dut12 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_state(din),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_state(os2), .busy(bz[2]));

  inv_quarter_round u_qr (
    .a(qa), .b(qb), .c(qc), .d(qd), .a0(ra), .b0(rb), .c0(rc), .d0(rd));

  typedef struct {
    string        name;
    int           k;
    logic [511:0] d;
    logic [511:0] e;
  } vec_t;

  vec_t vecs [$];

  logic [31:0] rfc_out [16] = '{
    32'h837778ab, 32'he238d763, 32'ha67ae21e, 32'h5950bb2f,
    32'hc4f2d0c7, 32'hfc62bb2f, 32'h8fa018fc, 32'h3f5ec7b7,
    32'h335271c2, 32'hf29489f3, 32'heabda8fc, 32'h82e46ebd,
    32'hd19c12b4, 32'hb04e16de, 32'h9e83d0cb, 32'h4e3c50a2};
  logic [31:0] rfc_in [16] = '{
    32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
    32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
    32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
    32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] fqr(input logic [31:0] a, b, c, d);
    a += b; d ^= a; d = rotl(d, 16);
    c += d; b ^= c; b = rotl(b, 12);
    a += b; d ^= a; d = rotl(d, 8);
    c += d; b ^= c; b = rotl(b, 7);
    return {a, b, c, d};
  endfunction

  // Reference forward permutation: column round then diagonal round, repeated.
  function automatic logic [511:0] fwd_perm(input logic [511:0] s, input int rounds);
    logic [31:0]  x [16];
    logic [127:0] r;
    logic [511:0] o;
    int ia, ib, ic, id;
    for (int i = 0; i < 16; i++) x[i] = s[32*i +: 32];
    for (int rr = 0; rr < rounds / 2; rr++) begin
      for (int h = 0; h < 2; h++) begin
        for (int q = 0; q < 4; q++) begin
          ia = q;
          ib = 4 + ((q + h) % 4);
          ic = 8 + ((q + 2 * h) % 4);
          id = 12 + ((q + 3 * h) % 4);
          r = fqr(x[ia], x[ib], x[ic], x[id]);
          {x[ia], x[ib], x[ic], x[id]} = r;
        end
      end
    end
    for (int i = 0; i < 16; i++) o[32*i +: 32] = x[i];
    return o;
  endfunction

  function automatic logic [511:0] pack16(input logic [31:0] w [16]);
    logic [511:0] o;
    for (int i = 0; i < 16; i++) o[32*i +: 32] = w[i];
    return o;
  endfunction

  function automatic logic [511:0] rand_state();
    logic [511:0] o;
    for (int i = 0; i < 16; i++) o[32*i +: 32] = $urandom();
    return o;
  endfunction

  function automatic logic [511:0] outs(input int k);
    return (k == 0) ? os0 : (k == 1) ? os1 : os2;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Accept one state, wait (bounded) for out_valid, check latency and result, then drain.
  task automatic run_vec(input int k, input logic [511:0] d, input logic [511:0] e,
                         input string name);
    int cyc;
    check({name, " in_ready"}, 512'(ir[k]), 512'(1));
    din   = d;
    iv[k] = 1'b1;
    @(posedge clk); #1;
    iv[k] = 1'b0;
    cyc = 0;
    while (!ov[k] && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, " latency"}, 512'(cyc), 512'(rnd[k]));
    check({name, " out_state"}, outs(k), e);
    ordy[k] = 1'b1;
    @(posedge clk); #1;
    ordy[k] = 1'b0;
    check({name, " in_ready after drain"}, 512'(ir[k]), 512'(1));
  endtask

  initial begin
    logic [511:0] s;
    int cyc;
    vec_t v;

    rst  = 1'b1;
    iv   = '0;
    ordy = '0;
    din  = '0;
    qa = 32'hea2a92f4; qb = 32'hcb1cf8ce; qc = 32'h4581472e; qd = 32'h5881c4bb;

    v.name = "zero";  v.k = 0; v.d = '0; v.e = '0; vecs.push_back(v);
    v.name = "rfc";   v.k = 0; v.d = pack16(rfc_out); v.e = pack16(rfc_in); vecs.push_back(v);
    for (int i = 0; i < 200; i++) begin
      v.k    = (i < 150) ? 0 : (i < 175) ? 1 : 2;
      v.name = $sformatf("rand%0d_r%0d", i, rnd[v.k]);
      v.e    = rand_state();
      v.d    = fwd_perm(v.e, rnd[v.k]);
      vecs.push_back(v);
    end

    repeat (2) @(posedge clk);
    #1;
    check("qr rfc 2.1.1", {ra, rb, rc, rd},
          {32'h11111111, 32'h01020304, 32'h9b8d6f43, 32'h01234567});
    check("reset in_ready",  512'(ir), 512'(3'b111));
    check("reset out_valid", 512'(ov), 512'(3'b000));
    check("reset busy",      512'(bz), 512'(3'b000));
    check("reset out_state", {os0, os1, os2}, '0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i].k, vecs[i].d, vecs[i].e, vecs[i].name);

    // Backpressure with in_valid held high through RUN and DONE.
    s   = rand_state();
    din = fwd_perm(s, 20);
    iv[0] = 1'b1;
    @(posedge clk); #1;
    din = rand_state();
    cyc = 0;
    while (!ov[0] && cyc < 200) begin
      check("bp run busy", 512'({bz[0], ir[0]}), 512'(2'b10));
      @(posedge clk); #1;
      cyc++;
    end
    check("bp latency", 512'(cyc), 512'(20));
    for (int i = 0; i < 7; i++) begin
      check("bp hold out_state", os0, s);
      check("bp hold flags", 512'({ov[0], ir[0], bz[0]}), 512'(3'b101));
      @(posedge clk); #1;
    end
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    iv[0]   = 1'b0;
    check("bp after handshake flags", 512'({ov[0], ir[0], bz[0]}), 512'(3'b010));
    @(posedge clk); #1;
    check("bp idle stays idle", 512'({ov[0], ir[0], bz[0]}), 512'(3'b010));

    // Abort in the middle of RUN, then confirm a clean recovery.
    din   = fwd_perm(rand_state(), 20);
    iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("abort still running", 512'(bz[0]), 512'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort flags", 512'({ov[0], ir[0], bz[0]}), 512'(3'b010));
    check("abort out_state", os0, '0);
    run_vec(0, pack16(rfc_out), pack16(rfc_in), "after abort rfc");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
